// File: rtl/npower_mem_responder_pkg.sv
// Shared nPower definitions: memory-responder FSM states, request record and reset PC.
package nPowerPkg;

  localparam logic [31:0] RESET_PC = 32'hFFFD0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } mem_rsp_state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } mem_rsp_req_t;

endpackage

// File: rtl/npower_mem_ram.sv
// Single-port DEPTH x 32 RAM, one 8-bit lane per byte enable, registered read.
module npower_mem_ram #(
  parameter int DEPTH = 4096,
  parameter int IW    = 12,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [LANES-1:0]      we,
  input  logic [IW-1:0]         adr,
  input  logic [LANES-1:0][7:0] wdat,
  output logic [LANES-1:0][7:0] rdat
);

  for (genvar b = 0; b < LANES; b++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we[b]) mem[adr] <= wdat[b];
        rd_q <= mem[adr];
      end
    end

    assign rdat[b] = rd_q;
  end

endmodule

// File: rtl/npower_mem_responder.sv
// Bus memory responder with programmable wait states and four-phase ack handshake.
// Define NPOWER_MEMRSP_ERR_EN to answer out-of-window accesses with err_o instead of ack_o.
module npower_mem_responder
  import nPowerPkg::*;
#(
  parameter int              AWID        = 32,
  parameter logic [AWID-1:0] BASE_ADR    = AWID'(RESET_PC),
  parameter int              DEPTH       = 4096,
  parameter int              WAIT_STATES = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic            we_i,
  input  logic [3:0]      sel_i,
  input  logic [AWID-1:0] adr_i,
  input  logic [31:0]     dat_i,
  output logic            ack_o,
  output logic            err_o,
  output logic [31:0]     dat_o
);

  localparam int            IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWID:0] WIN_BYTES = (AWID+1)'(64'(DEPTH) * 64'd4);
  localparam logic [3:0]    WS_M1     = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
`ifdef NPOWER_MEMRSP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  mem_rsp_state_e  state, nstate;
  logic [3:0]      cnt, cnt_n;
  logic            go_ack;
  logic [AWID-1:0] adr_q;
  mem_rsp_req_t    req_q;

  logic [AWID-1:0] acc_adr, off;
  logic            acc_we, in_win;
  logic [3:0]      acc_sel;
  logic [31:0]     acc_dat, rdat;

  // With zero wait states the RAM fires on the accepting edge, before the request is latched.
  assign acc_adr = (state == IDLE) ? adr_i : adr_q;
  assign acc_we  = (state == IDLE) ? we_i  : req_q.we;
  assign acc_sel = (state == IDLE) ? sel_i : req_q.sel;
  assign acc_dat = (state == IDLE) ? dat_i : req_q.dat;

  // Subtract-then-compare makes addresses below the base wrap to huge offsets.
  assign off    = acc_adr - BASE_ADR;
  assign in_win = {1'b0, off} < WIN_BYTES;

  npower_mem_ram #(.DEPTH(DEPTH), .IW(IW), .LANES(4)) u_ram (
    .clk  (clk_i),
    .en   (go_ack && !rst_i),
    .we   ((acc_we && in_win) ? acc_sel : 4'b0000),
    .adr  (off[IW+1:2]),
    .wdat (acc_dat),
    .rdat (rdat)
  );

  always_comb begin
    nstate = state;
    cnt_n  = cnt;
    go_ack = 1'b0;
    unique case (state)
      IDLE: begin
        if (cyc_i && stb_i) begin
          if (WAIT_STATES == 0) begin
            nstate = ACK;
            go_ack = 1'b1;
          end else begin
            nstate = WAIT;
            cnt_n  = WS_M1;
          end
        end
      end
      WAIT: begin
        if (!cyc_i) begin
          nstate = IDLE;
        end else if (cnt == 4'd0) begin
          nstate = ACK;
          go_ack = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ACK:     if (!(cyc_i && stb_i)) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
      adr_q <= '0;
      req_q <= '0;
      ack_o <= 1'b0;
      dat_o <= 32'h0;
    end else begin
      state <= nstate;
      cnt   <= cnt_n;
      if (state == IDLE && cyc_i && stb_i) begin
        adr_q <= adr_i;
        req_q <= '{we: we_i, sel: sel_i, dat: dat_i};
      end
      // First ACK cycle waits for the registered RAM read; the response goes out on the next edge.
      if (state == ACK) begin
        if (!(cyc_i && stb_i)) begin
          ack_o <= 1'b0;
        end else if (!ack_o && !err_o && (in_win || !ERR_EN)) begin
          ack_o <= 1'b1;
          if (!req_q.we) dat_o <= in_win ? rdat : 32'h0;
        end
      end
    end
  end

`ifdef NPOWER_MEMRSP_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (state == ACK) begin
      if (!(cyc_i && stb_i))                   err_q <= 1'b0;
      else if (!ack_o && !err_q && !in_win)    err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
